aes_sram_resp: RTL and testbench
================================

Name: aes_sram_resp

Overview:
- Responder side of the AES datapath SRAM request interface (sramRead/sramWrite/sramDump/sramInit/sramAddr).
- Holds the 128-bit state/key words that the round stages (sub-bytes, shift-rows, mix-columns, add-round-key) read, transform and write back.
- Services single-word reads and writes, multi-word zero-init bursts, and multi-word dump bursts to a debug/output stream.

Parameters:
- DEPTH, 8, number of 128-bit words held (power of 2, 2..256).
- AW, 3, word-index width, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- sramRead  input  1  single-word read request
- sramWrite  input  1  single-word write request
- sramDump  input  1  dump-burst request
- sramInit  input  1  zero-init burst request
- sramAddr  input  16  byte address; word index = sramAddr[AW+3:4]; bits [3:0] ignored
- sramWriteValue  input  128  write data
- sramDumpNum  input  3  dump burst length minus 1 (0 -> 1 word, 7 -> 8 words)
- sramInitNum  input  3  init burst length minus 1
- sramReadValue  output  128  registered read data
- busy  output  1  high while an init or dump burst is in progress
- dump_valid  output  1  dump_data/dump_addr valid this cycle
- dump_data  output  128  dumped word
- dump_addr  output  16  byte address of dumped word (index << 4)
- addr_error  output  1  one-cycle pulse: out-of-range request

Behaviour:
- Clock and reset: clk rising edge; n_rst asynchronous, active-low. Reset: all memory words = 0; sramReadValue = 0; busy = 0; dump_valid = 0; dump_data = 0; dump_addr = 0; addr_error = 0; FSM = IDLE.
- Range check: a request is out of range when sramAddr >= DEPTH*16. The request is dropped, and addr_error pulses high the next cycle. Out-of-range reads leave sramReadValue unchanged.
- Requests are sampled only in IDLE. Requests asserted while busy = 1 are ignored; there is no queuing.
- Priority when several requests are high in the same cycle: sramInit > sramDump > sramWrite > sramRead. Only the winner is serviced.
- Write: mem[idx] <= sramWriteValue on the sampling edge, so it is visible to a read issued on the next cycle.
- Read: sramReadValue <= mem[idx] on the sampling edge, giving data valid 1 cycle after the request. The value holds until the next serviced read, so requesters may sample it any number of cycles later.
- FSM states:
  - IDLE: accept requests. Init -> INIT; dump -> DUMP. Latch the start index and the count (Num+1).
  - INIT: write 0 to mem[ptr] each cycle, ptr = (ptr+1) mod DEPTH. Decrement count. On the cycle count reaches 0 -> IDLE. busy = 1 throughout INIT. An N-word init occupies N cycles, and busy drops the cycle after the last word is written.
  - DUMP: each cycle, dump_valid = 1, dump_data = mem[ptr], dump_addr = ptr<<4, then ptr = (ptr+1) mod DEPTH and count is decremented. Exit to IDLE after the last word. The first dump word appears the cycle after the request. busy = 1 throughout DUMP.
- Bursts wrap modulo DEPTH; a burst longer than DEPTH revisits words.
- Outside DUMP, dump_valid = 0 and dump_data/dump_addr hold their last values.
- Reset mid-burst: immediate return to IDLE, memory cleared, outputs at reset values.

Test Plan:
- Reset, then write 128'h00112233_44556677_8899aabb_ccddeeff to addr 32, then read addr 32 -> sramReadValue equals that value 1 cycle after the read pulse and holds for 5+ idle cycles.
- Shift-rows style sequence: read addr 32, 2 idle cycles, write transformed word to addr 32, read again -> the new word is returned.
- Write words A..H to indices 0..7, then dump addr 16 with sramDumpNum = 7 -> 8 consecutive dump_valid cycles, dump_addr 16,32,...,112,0, data B..H,A; busy high for 8 cycles.
- Init addr 48 with sramInitNum = 2 -> indices 3,4,5 read 0, others unchanged; a sramWrite issued during busy is ignored.
- Simultaneous sramWrite + sramRead at addr 0 -> write performed, sramReadValue unchanged; sramAddr = 16'h0080 (DEPTH = 8) -> addr_error pulses once, memory unchanged.
- Assert n_rst low during the 4th cycle of an 8-word dump -> busy and dump_valid drop immediately, all words read back 0.

Source files
------------

// File: rtl/aes_sram_resp.sv
// Word store for the AES round datapath: single-word read/write plus
// zero-init and dump bursts that walk the array modulo DEPTH.
module aes_sram_resp #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         sramRead,
  input  logic         sramWrite,
  input  logic         sramDump,
  input  logic         sramInit,
  input  logic [15:0]  sramAddr,
  input  logic [127:0] sramWriteValue,
  input  logic [2:0]   sramDumpNum,
  input  logic [2:0]   sramInitNum,
  output logic [127:0] sramReadValue,
  output logic         busy,
  output logic         dump_valid,
  output logic [127:0] dump_data,
  output logic [15:0]  dump_addr,
  output logic         addr_error
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  INIT  = 2'd1;
  localparam logic [1:0]  DUMP  = 2'd2;
  localparam logic [16:0] LIMIT = 17'(DEPTH * 16);

  logic [127:0]  mem_r [DEPTH];
  logic [1:0]    state_r;
  logic [AW-1:0] ptr_r;
  logic [3:0]    count_r;

  logic [AW-1:0] idx_s;
  logic          range_err_s;
  logic          idle_s;
  logic          any_req_s;
  logic          do_init_s;
  logic          do_dump_s;
  logic          do_write_s;
  logic          do_read_s;

  // Request decode: fixed priority init > dump > write > read, IDLE only.
  always_comb begin
    idx_s       = sramAddr[AW+3:4];
    range_err_s = ({1'b0, sramAddr} >= LIMIT);
    idle_s      = (state_r == IDLE);
    any_req_s   = idle_s && (sramInit || sramDump || sramWrite || sramRead);
    do_init_s   = idle_s && !range_err_s && sramInit;
    do_dump_s   = idle_s && !range_err_s && !sramInit && sramDump;
    do_write_s  = idle_s && !range_err_s && !sramInit && !sramDump && sramWrite;
    do_read_s   = idle_s && !range_err_s && !sramInit && !sramDump && !sramWrite && sramRead;
  end

  // Storage array: host writes from IDLE, zero fill while in INIT.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 128'd0;
      end
    end else if (do_write_s) begin
      mem_r[idx_s] <= sramWriteValue;
    end else if (state_r == INIT) begin
      mem_r[ptr_r] <= 128'd0;
    end
  end

  // Burst sequencer and registered response outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= IDLE;
      ptr_r         <= '0;
      count_r       <= 4'd0;
      busy          <= 1'b0;
      dump_valid    <= 1'b0;
      dump_data     <= 128'd0;
      dump_addr     <= 16'd0;
      sramReadValue <= 128'd0;
      addr_error    <= 1'b0;
    end else begin
      addr_error <= any_req_s && range_err_s;
      case (state_r)
        IDLE: begin
          dump_valid <= 1'b0;
          if (do_init_s) begin
            state_r <= INIT;
            busy    <= 1'b1;
            ptr_r   <= idx_s;
            count_r <= {1'b0, sramInitNum} + 4'd1;
          end else if (do_dump_s) begin
            // First word goes out on the request edge; count holds words still to send.
            state_r    <= DUMP;
            busy       <= 1'b1;
            dump_valid <= 1'b1;
            dump_data  <= mem_r[idx_s];
            dump_addr  <= {{(12-AW){1'b0}}, idx_s, 4'b0000};
            ptr_r      <= idx_s + AW'(1);
            count_r    <= {1'b0, sramDumpNum};
          end else if (do_read_s) begin
            sramReadValue <= mem_r[idx_s];
          end
        end
        INIT: begin
          ptr_r   <= ptr_r + AW'(1);
          count_r <= count_r - 4'd1;
          if (count_r == 4'd1) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        DUMP: begin
          if (count_r == 4'd0) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            dump_valid <= 1'b0;
          end else begin
            dump_valid <= 1'b1;
            dump_data  <= mem_r[ptr_r];
            dump_addr  <= {{(12-AW){1'b0}}, ptr_r, 4'b0000};
            ptr_r      <= ptr_r + AW'(1);
            count_r    <= count_r - 4'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          dump_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sram_resp.sv
// Directed bench for aes_sram_resp: inputs driven and outputs sampled on the
// falling edge, every expectation is a hand-chosen constant or table entry.
module tb_aes_sram_resp;

  logic         clk;
  logic         n_rst;
  logic         sramRead;
  logic         sramWrite;
  logic         sramDump;
  logic         sramInit;
  logic [15:0]  sramAddr;
  logic [127:0] sramWriteValue;
  logic [2:0]   sramDumpNum;
  logic [2:0]   sramInitNum;
  logic [127:0] sramReadValue;
  logic         busy;
  logic         dump_valid;
  logic [127:0] dump_data;
  logic [15:0]  dump_addr;
  logic         addr_error;

  int errors = 0;
  int checks = 0;

  logic [127:0] w [8];

  localparam logic [127:0] V1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V2 = 128'h00556aff_44996e33_88dda277_cc11e6bb;
  localparam logic [127:0] VX = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
  localparam logic [127:0] VZ = 128'h0f0f0f0f_1e1e1e1e_2d2d2d2d_3c3c3c3c;
  localparam logic [127:0] VQ = 128'hffffffff_00000000_ffffffff_00000000;

  aes_sram_resp #(.DEPTH(8), .AW(3)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .sramRead       (sramRead),
    .sramWrite      (sramWrite),
    .sramDump       (sramDump),
    .sramInit       (sramInit),
    .sramAddr       (sramAddr),
    .sramWriteValue (sramWriteValue),
    .sramDumpNum    (sramDumpNum),
    .sramInitNum    (sramInitNum),
    .sramReadValue  (sramReadValue),
    .busy           (busy),
    .dump_valid     (dump_valid),
    .dump_data      (dump_data),
    .dump_addr      (dump_addr),
    .addr_error     (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [127:0] v);
    @(negedge clk);
    sramWrite = 1'b1; sramAddr = a; sramWriteValue = v;
    @(negedge clk);
    sramWrite = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    sramRead = 1'b1; sramAddr = a;
    @(negedge clk);
    sramRead = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) w[i] = {4{32'hA5A50000 | 32'(i)}};
    n_rst = 1'b0; sramRead = 1'b0; sramWrite = 1'b0; sramDump = 1'b0; sramInit = 1'b0;
    sramAddr = 16'd0; sramWriteValue = 128'd0; sramDumpNum = 3'd0; sramInitNum = 3'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rv", sramReadValue, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_dv", {127'd0, dump_valid}, 128'd0);
    chk("rst_dd", dump_data, 128'd0);
    chk("rst_da", {112'd0, dump_addr}, 128'd0);
    chk("rst_ae", {127'd0, addr_error}, 128'd0);
    n_rst = 1'b1;

    // Write then read, value holds while idle
    wr(16'd32, V1);
    rd(16'd32);
    chk("rd_v1", sramReadValue, V1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_v1", sramReadValue, V1);
    end

    // Read, transform, write back, re-read
    rd(16'd32);
    chk("sr_rd", sramReadValue, V1);
    repeat (2) @(negedge clk);
    wr(16'd32, V2);
    rd(16'd32);
    chk("sr_new", sramReadValue, V2);

    // Fill A..H then wrapping 8-word dump from index 1
    for (int i = 0; i < 8; i++) wr(16'(i * 16), w[i]);
    @(negedge clk);
    sramDump = 1'b1; sramAddr = 16'd16; sramDumpNum = 3'd7;
    @(negedge clk);
    sramDump = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("dump_dv", {127'd0, dump_valid}, 128'd1);
      chk("dump_busy", {127'd0, busy}, 128'd1);
      chk("dump_addr", {112'd0, dump_addr}, 128'(((k + 1) % 8) * 16));
      chk("dump_data", dump_data, w[(k + 1) % 8]);
      @(negedge clk);
    end
    chk("dump_end_dv", {127'd0, dump_valid}, 128'd0);
    chk("dump_end_busy", {127'd0, busy}, 128'd0);
    chk("dump_hold_addr", {112'd0, dump_addr}, 128'd0);
    chk("dump_hold_data", dump_data, w[0]);

    // 3-word init at index 3, write during busy ignored
    @(negedge clk);
    sramInit = 1'b1; sramAddr = 16'd48; sramInitNum = 3'd2;
    @(negedge clk);
    sramInit = 1'b0;
    sramWrite = 1'b1; sramAddr = 16'd0; sramWriteValue = VX;
    chk("init_busy0", {127'd0, busy}, 128'd1);
    @(negedge clk);
    sramWrite = 1'b0;
    chk("init_busy1", {127'd0, busy}, 128'd1);
    @(negedge clk);
    chk("init_busy2", {127'd0, busy}, 128'd1);
    @(negedge clk);
    chk("init_done", {127'd0, busy}, 128'd0);
    for (int i = 0; i < 8; i++) begin
      rd(16'(i * 16));
      chk("init_word", sramReadValue, (i >= 3 && i <= 5) ? 128'd0 : w[i]);
    end

    // Write beats read when both asserted
    rd(16'd16);
    chk("pre_wr_rd", sramReadValue, w[1]);
    @(negedge clk);
    sramWrite = 1'b1; sramRead = 1'b1; sramAddr = 16'd0; sramWriteValue = VZ;
    @(negedge clk);
    sramWrite = 1'b0; sramRead = 1'b0;
    chk("prio_rv_hold", sramReadValue, w[1]);
    rd(16'd0);
    chk("prio_written", sramReadValue, VZ);

    // Out-of-range write and read
    chk("ae_idle", {127'd0, addr_error}, 128'd0);
    @(negedge clk);
    sramWrite = 1'b1; sramAddr = 16'h0080; sramWriteValue = VQ;
    @(negedge clk);
    sramWrite = 1'b0;
    chk("ae_pulse", {127'd0, addr_error}, 128'd1);
    @(negedge clk);
    chk("ae_clear", {127'd0, addr_error}, 128'd0);
    rd(16'h0080);
    chk("ae_rd_pulse", {127'd0, addr_error}, 128'd1);
    chk("oor_rv_hold", sramReadValue, VZ);
    rd(16'd0);
    chk("oor_mem_keep", sramReadValue, VZ);

    // Reset during the 4th word of an 8-word dump
    @(negedge clk);
    sramDump = 1'b1; sramAddr = 16'd0; sramDumpNum = 3'd7;
    @(negedge clk);
    sramDump = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_dv", {127'd0, dump_valid}, 128'd1);
    chk("mid_addr", {112'd0, dump_addr}, 128'd48);
    n_rst = 1'b0;
    #1;
    chk("mrst_busy", {127'd0, busy}, 128'd0);
    chk("mrst_dv", {127'd0, dump_valid}, 128'd0);
    chk("mrst_dd", dump_data, 128'd0);
    chk("mrst_da", {112'd0, dump_addr}, 128'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(16'(i * 16));
      chk("mrst_word", sramReadValue, 128'd0);
    end
    chk("mrst_idle", {127'd0, busy}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
